subleq_sequencer: RTL and testbench



---
 rtl/subleq_sequencer.sv | 165 ++++++++++++++++
 tb/tb_subleq_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - SUBLEQ instruction sequencer with a 4-phase req/ack memory port
// Fetches operands, stores DB-DA and branches; supports run/step, halt requests and negative-target halt.
module subleq_sequencer #(
  parameter int WORD_BITS   = 16,
  parameter int ADDR_BITS   = 16,
  parameter int RESET_PC    = 0,
  parameter int HALT_ON_NEG = 1,
  parameter int COUNT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt_req,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [WORD_BITS-1:0]  mem_wdata,
  input  logic [WORD_BITS-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_BITS-1:0]  pc,
  output logic [COUNT_BITS-1:0] insn_count,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_DEREF_A, S_FETCH_B, S_DEREF_B, S_STORE, S_FETCH_C, S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic                  wait_q, wait_d;
  logic                  halt_pend_q, halt_pend_d;
  logic [ADDR_BITS-1:0]  pc_q, pc_d;
  logic [WORD_BITS-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, da_q, da_d, db_q, db_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;

  logic [WORD_BITS-1:0]  r;
  logic                  r_pos;
  logic                  mem_state;
  logic                  neg_target;

  assign r          = db_q - da_q;
  assign r_pos      = !r[WORD_BITS-1] && (r != '0);
  assign mem_state  = (state_q != S_IDLE) && (state_q != S_HALT);
  assign neg_target = (HALT_ON_NEG != 0) && c_q[WORD_BITS-1];

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      pc_q        <= ADDR_BITS'(RESET_PC);
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      da_q        <= '0;
      db_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      da_q        <= da_d;
      db_q        <= db_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    halt_pend_d = halt_pend_q;
    pc_d        = pc_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    da_d        = da_q;
    db_d        = db_q;
    cnt_d       = cnt_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    // Bus fields are only driven during the REQ phase so they read as zero otherwise.
    if (mem_state && !wait_q) begin
      mem_req = 1'b1;
      case (state_q)
        S_FETCH_A: mem_addr = pc_q;
        S_DEREF_A: mem_addr = a_q[ADDR_BITS-1:0];
        S_FETCH_B: mem_addr = pc_q + ADDR_BITS'(1);
        S_DEREF_B: mem_addr = b_q[ADDR_BITS-1:0];
        S_STORE: begin
          mem_addr  = b_q[ADDR_BITS-1:0];
          mem_we    = 1'b1;
          mem_wdata = r;
        end
        S_FETCH_C: mem_addr = pc_q + ADDR_BITS'(2);
        default:   mem_addr = '0;
      endcase
    end

    if (mem_state) halt_pend_d = halt_pend_q | halt_req;

    case (state_q)
      S_IDLE: begin
        wait_d = 1'b0;
        if (halt_req)         state_d = S_HALT;
        else if (run || step) state_d = S_FETCH_A;
      end
      S_HALT: begin
        wait_d = 1'b0;
      end
      default: begin
        if (!wait_q) begin
          if (mem_ack) begin
            wait_d = 1'b1;
            case (state_q)
              S_FETCH_A: a_d  = mem_rdata;
              S_DEREF_A: da_d = mem_rdata;
              S_FETCH_B: b_d  = mem_rdata;
              S_DEREF_B: db_d = mem_rdata;
              S_FETCH_C: c_d  = mem_rdata;
              default:   ;
            endcase
          end
        end else if (!mem_ack) begin
          wait_d = 1'b0;
          case (state_q)
            S_FETCH_A: state_d = S_DEREF_A;
            S_DEREF_A: state_d = S_FETCH_B;
            S_FETCH_B: state_d = S_DEREF_B;
            S_DEREF_B: state_d = S_STORE;
            S_STORE: begin
              if (r_pos) begin
                pc_d    = pc_q + ADDR_BITS'(3);
                cnt_d   = cnt_q + COUNT_BITS'(1);
                state_d = halt_pend_d ? S_HALT : S_IDLE;
              end else begin
                state_d = S_FETCH_C;
              end
            end
            S_FETCH_C: begin
              pc_d    = c_q[ADDR_BITS-1:0];
              cnt_d   = cnt_q + COUNT_BITS'(1);
              state_d = (halt_pend_d || neg_target) ? S_HALT : S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  assign pc         = pc_q;
  assign insn_count = cnt_q;
  assign busy       = mem_state;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_subleq_sequencer.sv
// tb/tb_subleq_sequencer.sv - scoreboard bench for subleq_sequencer
// Expected memory accesses are queued by the stimulus and popped by a bus monitor.
module tb_subleq_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 16-bit instance
  logic        areset = 1'b1, run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic        mem_req, mem_we, busy, halted;
  logic [15:0] mem_addr, mem_wdata, pc;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] insn_count;

  subleq_sequencer dut (
    .clk(clk), .areset(areset), .run(run), .step(step), .halt_req(halt_req),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .insn_count(insn_count),
    .busy(busy), .halted(halted)
  );

  // 8-bit instance
  logic        areset8 = 1'b1, run8 = 1'b0, step8 = 1'b0, halt8 = 1'b0;
  logic        req8, we8, busy8, halted8;
  logic [7:0]  addr8, wdata8, pc8;
  logic [7:0]  rdata8 = '0;
  logic        ack8 = 1'b0;
  logic [31:0] cnt8;

  subleq_sequencer #(.WORD_BITS(8), .ADDR_BITS(8)) dut8 (
    .clk(clk), .areset(areset8), .run(run8), .step(step8), .halt_req(halt8),
    .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
    .mem_rdata(rdata8), .mem_ack(ack8), .pc(pc8), .insn_count(cnt8),
    .busy(busy8), .halted(halted8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Memory models: stimulus owns init_*, the responder owns the write overlay.
  logic [15:0] init_mem [0:255];
  logic [15:0] wr_mem   [0:255];
  logic        wr_ok    [0:255];
  int          ack_delay = 0;
  int          dly = 0;

  function automatic logic [15:0] rd16(input logic [15:0] a);
    return wr_ok[a[7:0]] ? wr_mem[a[7:0]] : init_mem[a[7:0]];
  endfunction

  always @(posedge clk) begin
    if (areset) begin
      mem_ack <= 1'b0;
      dly     <= 0;
      for (int i = 0; i < 256; i++) wr_ok[i] <= 1'b0;
    end else if (mem_req && !mem_ack) begin
      if (dly < ack_delay) dly <= dly + 1;
      else begin
        dly       <= 0;
        mem_ack   <= 1'b1;
        mem_rdata <= rd16(mem_addr);
        if (mem_we) begin
          wr_mem[mem_addr[7:0]] <= mem_wdata;
          wr_ok[mem_addr[7:0]]  <= 1'b1;
        end
      end
    end else if (mem_ack && !mem_req) mem_ack <= 1'b0;
  end

  logic [7:0] init8 [0:255];
  logic [7:0] wr8   [0:255];
  logic       ok8   [0:255];

  function automatic logic [7:0] rd8(input logic [7:0] a);
    return ok8[a] ? wr8[a] : init8[a];
  endfunction

  always @(posedge clk) begin
    if (areset8) begin
      ack8 <= 1'b0;
      for (int i = 0; i < 256; i++) ok8[i] <= 1'b0;
    end else if (req8 && !ack8) begin
      ack8   <= 1'b1;
      rdata8 <= rd8(addr8);
      if (we8) begin
        wr8[addr8] <= wdata8;
        ok8[addr8] <= 1'b1;
      end
    end else if (ack8 && !req8) ack8 <= 1'b0;
  end

  // Scoreboard
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;
  acc_t exp_q[$];
  acc_t e;
  logic req_prev = 1'b0;
  int   acc_cnt = 0;

  task automatic push(input logic we, input logic [15:0] addr, input logic [15:0] data);
    exp_q.push_back('{we: we, addr: addr, data: data});
  endtask

  always @(negedge clk) begin
    if (mem_req && !req_prev) begin
      acc_cnt <= acc_cnt + 1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_access: got addr 0x%0h we %0b, required no access", mem_addr, mem_we);
      end else begin
        e = exp_q.pop_front();
        check("acc_we", 64'(mem_we), 64'(e.we));
        check("acc_addr", 64'(mem_addr), 64'(e.addr));
        if (e.we) check("acc_wdata", 64'(mem_wdata), 64'(e.data));
      end
    end
    if (!mem_req) check("idle_bus", {31'd0, mem_we, mem_addr, mem_wdata}, 64'd0);
    req_prev <= mem_req;
  end

  task automatic kick(input logic use_step);
    @(negedge clk);
    if (use_step) step = 1'b1; else run = 1'b1;
    @(negedge clk);
    step = 1'b0;
    run  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic wait_done8(input string name);
    int n = 0;
    while (!busy8 && n < 50) begin @(negedge clk); n++; end
    while (busy8 && n < 3000) begin @(negedge clk); n++; end
    check(name, 64'(busy8), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = '0;
      init8[i]    = '0;
    end
    repeat (2) @(negedge clk);
    areset = 1'b0;
    areset8 = 1'b0;

    // reset state
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_cnt", 64'(insn_count), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // positive result skips C fetch
    init_mem[0] = 3; init_mem[1] = 4; init_mem[2] = 6; init_mem[3] = 5; init_mem[4] = 7;
    push(0, 0, 0); push(0, 3, 0); push(0, 1, 0); push(0, 4, 0); push(1, 4, 2);
    kick(0);
    wait_done("t1_done");
    check("t1_pc", 64'(pc), 64'd3);
    check("t1_cnt", 64'(insn_count), 64'd1);
    check("t1_mem4", 64'(rd16(4)), 64'd2);
    check("t1_halted", 64'(halted), 64'd0);

    // zero result branches through C
    do_reset();
    init_mem[0] = 3; init_mem[1] = 3; init_mem[2] = 8; init_mem[3] = 5;
    push(0, 0, 0); push(0, 3, 0); push(0, 1, 0); push(0, 3, 0); push(1, 3, 0); push(0, 2, 0);
    kick(0);
    wait_done("t2_done");
    check("t2_pc", 64'(pc), 64'd8);
    check("t2_mem3", 64'(rd16(3)), 64'd0);
    check("t2_cnt", 64'(insn_count), 64'd1);
    check("t2_halted", 64'(halted), 64'd0);

    // single step; a second step mid-instruction is ignored
    init_mem[8] = 20; init_mem[9] = 21; init_mem[10] = 12; init_mem[20] = 1; init_mem[21] = 10;
    push(0, 8, 0); push(0, 20, 0); push(0, 9, 0); push(0, 21, 0); push(1, 21, 9);
    kick(1);
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_done("t4_done");
    check("t4_pc", 64'(pc), 64'd11);
    check("t4_cnt", 64'(insn_count), 64'd2);
    check("t4_mem21", 64'(rd16(21)), 64'd9);
    repeat (20) @(negedge clk);
    check("t4_idle_busy", 64'(busy), 64'd0);
    check("t4_idle_cnt", 64'(insn_count), 64'd2);

    // halt_req during DEREF_B WAIT finishes the instruction, then halts
    init_mem[11] = 30; init_mem[12] = 31; init_mem[13] = 40; init_mem[30] = 5; init_mem[31] = 3;
    push(0, 11, 0); push(0, 30, 0); push(0, 12, 0); push(0, 31, 0); push(1, 31, 16'hFFFE); push(0, 13, 0);
    base = acc_cnt;
    kick(1);
    n = 0;
    while (!(acc_cnt == base + 4 && !mem_req) && n < 500) begin @(negedge clk); n++; end
    check("t5_reach_derefb", 64'(acc_cnt - base), 64'd4);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    wait_done("t5_done");
    check("t5_halted", 64'(halted), 64'd1);
    check("t5_pc", 64'(pc), 64'd40);
    check("t5_cnt", 64'(insn_count), 64'd3);
    check("t5_mem31", 64'(rd16(31)), 64'hFFFE);
    run = 1'b1;
    step = 1'b1;
    repeat (20) @(negedge clk);
    run = 1'b0;
    step = 1'b0;
    check("t5_stay_halted", 64'(halted), 64'd1);
    check("t5_stay_cnt", 64'(insn_count), 64'd3);

    // 8-bit instance: positive R=0x7F, then negative-target halt
    init8[0] = 8'h10; init8[1] = 8'h11; init8[2] = 8'h20; init8[8'h10] = 8'h01; init8[8'h11] = 8'h80;
    @(negedge clk);
    run8 = 1'b1;
    @(negedge clk);
    run8 = 1'b0;
    wait_done8("t3a_done");
    check("t3a_pc", 64'(pc8), 64'd3);
    check("t3a_mem11", 64'(rd8(8'h11)), 64'h7F);
    check("t3a_halted", 64'(halted8), 64'd0);
    @(negedge clk);
    areset8 = 1'b1;
    @(negedge clk);
    areset8 = 1'b0;
    init8[0] = 8'h12; init8[1] = 8'h13; init8[2] = 8'hF0; init8[8'h12] = 8'h05; init8[8'h13] = 8'h05;
    run8 = 1'b1;
    @(negedge clk);
    run8 = 1'b0;
    wait_done8("t3b_done");
    check("t3b_halted", 64'(halted8), 64'd1);
    check("t3b_pc", 64'(pc8), 64'hF0);
    check("t3b_cnt", 64'(cnt8), 64'd1);

    // reset during a stalled STORE REQ
    init_mem[0] = 3; init_mem[1] = 4; init_mem[2] = 6; init_mem[3] = 5; init_mem[4] = 7;
    do_reset();
    ack_delay = 6;
    push(0, 0, 0); push(0, 3, 0); push(0, 1, 0); push(0, 4, 0); push(1, 4, 2);
    base = acc_cnt;
    kick(0);
    n = 0;
    while (acc_cnt < base + 5 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t6_store_req", {62'd0, mem_req, mem_we}, 64'd3);
    areset = 1'b1;
    @(negedge clk);
    check("t6_req_low", 64'(mem_req), 64'd0);
    check("t6_pc", 64'(pc), 64'd0);
    check("t6_cnt", 64'(insn_count), 64'd0);
    areset = 1'b0;
    ack_delay = 0;
    push(0, 0, 0); push(0, 3, 0); push(0, 1, 0); push(0, 4, 0); push(1, 4, 2);
    kick(0);
    wait_done("t6_done");
    check("t6_restart_pc", 64'(pc), 64'd3);
    check("t6_restart_cnt", 64'(insn_count), 64'd1);
    check("t6_restart_mem4", 64'(rd16(4)), 64'd2);

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
